// File: rtl/console_pkg.sv
// ============================================================================
// Module   : console_pkg
// Brief    : Shared serial-console constants, FSM encoding and char filter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package console_pkg;

    localparam logic [7:0] c_ESC    = 8'h1b;
    localparam logic [7:0] c_LBRACK = 8'h5b;
    localparam logic [7:0] c_CAP_H  = 8'h48;
    localparam logic [7:0] c_CR     = 8'h0d;
    localparam logic [7:0] c_LF     = 8'h0a;
    localparam logic [7:0] c_SPACE  = 8'h20;

    localparam int c_DEFAULT_COLS = 80;
    localparam int c_DEFAULT_ROWS = 60;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOME  = 3'd1,
        S_ADDR  = 3'd2,
        S_WAIT  = 3'd3,
        S_SEND  = 3'd4,
        S_CR    = 3'd5,
        S_LF    = 3'd6,
        S_DRAIN = 3'd7
    } dump_state_t;

    // Anything outside printable ASCII goes out as a space so the host never sees escapes.
    function automatic logic [7:0] printable(input logic [7:0] ch);
        return ((ch < 8'd32) || (ch > 8'd126)) ? c_SPACE : ch;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 UART transmitter, LSB first, with valid/ready byte input.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx
    import console_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);

    localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

    logic                r_busy;
    logic [c_BAUD_W-1:0] r_baud;
    logic [3:0]          r_bit;
    logic [8:0]          r_shift;
    logic                r_tx;

    assign byte_ready = ~r_busy;
    assign tx         = r_tx;

    // r_bit 0 is the start bit, 1..8 data, 9 the stop bit; r_shift keeps the stop bit at its top.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '1;
            r_tx    <= 1'b1;
        end else if (!r_busy) begin
            if (byte_valid) begin
                r_busy  <= 1'b1;
                r_baud  <= '0;
                r_bit   <= '0;
                r_shift <= {1'b1, byte_data};
                r_tx    <= 1'b0;
            end
        end else if (r_baud == c_BAUD_LAST) begin
            r_baud <= '0;
            if (r_bit == 4'd9) begin
                r_busy <= 1'b0;
                r_tx   <= 1'b1;
            end else begin
                r_bit   <= r_bit + 4'd1;
                r_tx    <= r_shift[0];
                r_shift <= {1'b1, r_shift[8:1]};
            end
        end else begin
            r_baud <= r_baud + c_BAUD_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/screen_dump_tx.sv
// ============================================================================
// Module   : screen_dump_tx
// Brief    : Reads the text buffer and sends it over UART as a screen refresh.
// Revision : 1.0
// ============================================================================
`default_nettype none

module screen_dump_tx
    import console_pkg::*;
#(
    parameter int COLS         = c_DEFAULT_COLS,
    parameter int ROWS         = c_DEFAULT_ROWS,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [12:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        tx
);

    localparam int                 c_COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int                 c_ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(COLS - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(ROWS - 1);

    dump_state_t        r_state;
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [1:0]         r_home_idx;
    logic [12:0]        r_rd_addr;
    logic               r_byte_valid;
    logic [7:0]         r_byte_data;
    logic               w_byte_ready;
    logic               w_done;
    logic               w_launch;

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (r_byte_valid),
        .byte_data  (r_byte_data),
        .byte_ready (w_byte_ready),
        .tx         (tx)
    );

    // The last frame has finished exactly when the UART reports ready while draining.
    assign w_done   = (r_state == S_DRAIN) && w_byte_ready;
    assign w_launch = start && ((r_state == S_IDLE) || w_done);
    assign done     = w_done;
    assign busy     = (r_state != S_IDLE) && !w_done;
    assign rd_addr  = r_rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_home_idx   <= '0;
            r_rd_addr    <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
        end else if (w_launch) begin
            r_state      <= S_HOME;
            r_col        <= '0;
            r_row        <= '0;
            r_home_idx   <= '0;
            r_rd_addr    <= '0;
            r_byte_valid <= 1'b1;
            r_byte_data  <= c_ESC;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_HOME: if (w_byte_ready) begin
                    if (r_home_idx == 2'd2) begin
                        r_byte_valid <= 1'b0;
                        r_state      <= S_ADDR;
                    end else begin
                        r_home_idx  <= r_home_idx + 2'd1;
                        r_byte_data <= (r_home_idx == 2'd0) ? c_LBRACK : c_CAP_H;
                    end
                end
                S_ADDR: r_state <= S_WAIT;
                // The next character is fetched while the previous frame is still on the wire.
                S_WAIT: begin
                    r_byte_data  <= printable(rd_data);
                    r_byte_valid <= 1'b1;
                    r_state      <= S_SEND;
                end
                S_SEND: if (w_byte_ready) begin
                    if (r_col == c_COL_LAST) begin
                        r_byte_data <= c_CR;
                        r_state     <= S_CR;
                    end else begin
                        r_col        <= r_col + c_COL_W'(1);
                        r_rd_addr    <= r_rd_addr + 13'd1;
                        r_byte_valid <= 1'b0;
                        r_state      <= S_ADDR;
                    end
                end
                S_CR: if (w_byte_ready) begin
                    r_byte_data <= c_LF;
                    r_state     <= S_LF;
                end
                // Row-major scan, so row*COLS+col always advances by one.
                S_LF: if (w_byte_ready) begin
                    r_byte_valid <= 1'b0;
                    if (r_row == c_ROW_LAST) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_row     <= r_row + c_ROW_W'(1);
                        r_col     <= '0;
                        r_rd_addr <= r_rd_addr + 13'd1;
                        r_state   <= S_ADDR;
                    end
                end
                S_DRAIN: if (w_byte_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
